i2c_config_sequencer: RTL

Upstream stage of the 3-byte I2C write controller. Walks a register table (codec/video-decoder init list), presents each entry as a 24-bit {slave, sub-addr, data} word and pulses GO. Waits for END, checks the 3-bit ACK vector and retries on NACK. Also generates the slow controller clock I2C_CTRL_CLK from the system clock, so the controller and its bus timing are driven entirely by this block.

---
 rtl/i2c_config_sequencer_if.sv | 28 ++
 rtl/i2c_config_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/i2c_config_sequencer_if.sv
// Bus between the config sequencer, its register table and the 3-byte I2C write controller.
// GO/END: the sequencer raises GO with I2C_DATA already stable, the controller drops END once
// it starts and raises it again when done with ACK final; GO low returns the controller to idle.
interface i2c_config_sequencer_if;
    logic        START;
    logic        I2C_CTRL_CLK;
    logic [23:0] I2C_DATA;
    logic        GO;
    logic        W_R;
    logic        END;
    logic [2:0]  ACK;
    logic [7:0]  LUT_INDEX;
    logic [15:0] LUT_DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic [2:0]  dbg_state;

    modport master (
        input  START, END, ACK, LUT_DATA,
        output I2C_CTRL_CLK, I2C_DATA, GO, W_R, LUT_INDEX, BUSY, DONE, ERROR, dbg_state
    );

    modport slave (
        output START, END, ACK, LUT_DATA,
        input  I2C_CTRL_CLK, I2C_DATA, GO, W_R, LUT_INDEX, BUSY, DONE, ERROR, dbg_state
    );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks an init register table, issuing one 3-byte I2C write per entry with NACK retry,
// and generates the controller clock; all sequencing advances on the controller clock's falling edge.
module i2c_config_sequencer #(
    parameter int       CLK_FREQ   = 50000000,
    parameter int       I2C_FREQ   = 20000,
    parameter int       LUT_SIZE   = 16,
    parameter bit [7:0] SLAVE_ADDR = 8'h34,
    parameter int       MAX_RETRY  = 3,
    parameter int       PWR_DELAY  = 4
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    i2c_config_sequencer_if.master bus
);

    localparam int DIV = CLK_FREQ / (2 * I2C_FREQ);

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_LOAD     = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_END = 3'd3,
        S_CHECK    = 3'd4,
        S_DONE     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] div_cnt;
    logic        ctrl_clk;
    logic        tick;
    logic [7:0]  dly;
    logic [3:0]  retry;
    logic [7:0]  lut_index;
    logic [2:0]  ack_q;
    logic [23:0] i2c_data;
    logic        start_pend;
    logic        start_seen;
    logic        retry_exhausted;
    logic        last_entry;
    logic        pwr_done;

    // tick marks the 1->0 edge so GO/I2C_DATA settle half a period before the controller samples
    assign tick = (div_cnt == 16'(DIV - 1)) && ctrl_clk;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt  <= '0;
            ctrl_clk <= 1'b1;
        end else if (div_cnt == 16'(DIV - 1)) begin
            div_cnt  <= '0;
            ctrl_clk <= ~ctrl_clk;
        end else begin
            div_cnt  <= div_cnt + 16'd1;
        end
    end

    assign retry_exhausted = (retry == 4'(MAX_RETRY));
    assign last_entry      = (lut_index == 8'(LUT_SIZE - 1));
    assign pwr_done        = (int'(dly) + 1 >= PWR_DELAY);
    assign start_seen      = start_pend || bus.START;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= S_PWR_WAIT;
        else if (tick) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_PWR_WAIT: if (pwr_done) state_nxt = S_LOAD;
            S_LOAD:     if (dly != 8'd0) state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (!bus.END)           state_nxt = S_WAIT_END;
                else if (dly == 8'd7)   state_nxt = retry_exhausted ? S_ERROR : S_LOAD;
            end
            S_WAIT_END: if (bus.END) state_nxt = S_CHECK;
            S_CHECK: begin
                if (ack_q == 3'b000)    state_nxt = last_entry ? S_DONE : S_LOAD;
                else                    state_nxt = retry_exhausted ? S_ERROR : S_LOAD;
            end
            S_DONE, S_ERROR: if (start_seen) state_nxt = S_PWR_WAIT;
            default:    state_nxt = S_PWR_WAIT;
        endcase
    end

    // START is only honoured while idle and held until the next tick picks it up
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            start_pend <= 1'b0;
        end else if (tick) begin
            start_pend <= 1'b0;
        end else if (bus.START && (state == S_DONE || state == S_ERROR)) begin
            start_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            dly       <= '0;
            retry     <= '0;
            lut_index <= '0;
            ack_q     <= '0;
            i2c_data  <= '0;
        end else if (tick) begin
            if (state_nxt != state) dly <= '0;
            else if (state == S_PWR_WAIT || state == S_LOAD || state == S_ISSUE) dly <= dly + 8'd1;

            case (state)
                S_LOAD:     i2c_data <= {SLAVE_ADDR, bus.LUT_DATA};
                S_ISSUE:    if (bus.END && dly == 8'd7 && !retry_exhausted) retry <= retry + 4'd1;
                S_WAIT_END: if (bus.END) ack_q <= bus.ACK;
                S_CHECK: begin
                    if (ack_q == 3'b000) begin
                        retry <= '0;
                        if (!last_entry) lut_index <= lut_index + 8'd1;
                    end else if (!retry_exhausted) begin
                        retry <= retry + 4'd1;
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start_seen) begin
                        retry     <= '0;
                        lut_index <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode straight from the state register so a reset drops GO immediately
    always_comb begin
        bus.GO           = (state == S_ISSUE) || (state == S_WAIT_END);
        bus.BUSY         = (state != S_DONE) && (state != S_ERROR);
        bus.DONE         = (state == S_DONE);
        bus.ERROR        = (state == S_ERROR);
        bus.W_R          = 1'b0;
        bus.I2C_CTRL_CLK = ctrl_clk;
        bus.I2C_DATA     = i2c_data;
        bus.LUT_INDEX    = lut_index;
        bus.dbg_state    = state;
    end

endmodule
